// File: rtl/spi_slave_fsm.sv
// SPI slave front end for the single-port RAM: turns MOSI frames into {cmd, payload} words
// and returns RAM read bytes on MISO, MSB first, with the master clocking one bit per clk.
module spi_slave_fsm #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    output logic              MISO
);

    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_CMD,
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [FRAME_W-2:0]   r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_frame_done;
    logic                 r_rd_addr_flag;
    logic [FRAME_W-1:0]   r_rx_data;
    logic                 r_rx_valid;

    logic [DATA_W-1:0]    r_tx_sr;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic                 r_tx_active;
    logic                 r_tx_latched;
    logic                 r_miso;

    logic                 w_sample;
    logic                 w_last_bit;
    logic                 w_tx_load;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus per-cycle sample / load strobes
    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_last_bit   = 1'b0;
        w_tx_load    = 1'b0;

        if (SS_n) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_CHK_CMD;
                end
                ST_CHK_CMD: begin
                    if (!MOSI) begin
                        w_next_state = ST_WRITE;
                    end else if (r_rd_addr_flag) begin
                        w_next_state = ST_READ_DATA;
                    end else begin
                        w_next_state = ST_READ_ADD;
                    end
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    w_sample   = !r_frame_done;
                    w_last_bit = !r_frame_done && (r_bit_cnt == '0);
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end

        // RAM byte is taken once, no earlier than the cycle after the rx_valid strobe
        w_tx_load = !SS_n && (r_state == ST_READ_DATA) && r_frame_done && !r_rx_valid
                    && !r_tx_latched && tx_valid;
    end

    // Frame deserialiser, address-phase flag and MISO serialiser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_frame_done   <= 1'b0;
            r_rd_addr_flag <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_tx_sr        <= '0;
            r_tx_cnt       <= '0;
            r_tx_active    <= 1'b0;
            r_tx_latched   <= 1'b0;
            r_miso         <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;

            if (SS_n) begin
                r_bit_cnt    <= '0;
                r_frame_done <= 1'b0;
                r_tx_cnt     <= '0;
                r_tx_active  <= 1'b0;
                r_tx_latched <= 1'b0;
                r_miso       <= 1'b0;
            end else begin
                if (r_state == ST_CHK_CMD) begin
                    r_shift      <= (FRAME_W-1)'(MOSI);
                    r_bit_cnt    <= CNT_W'(FRAME_W - 2);
                    r_frame_done <= 1'b0;
                end

                if (w_sample) begin
                    r_shift <= {r_shift[FRAME_W-3:0], MOSI};
                    if (w_last_bit) begin
                        r_frame_done <= 1'b1;
                        r_rx_valid   <= 1'b1;
                        r_rx_data    <= {r_shift, MOSI};
                        if (r_state == ST_READ_ADD) begin
                            r_rd_addr_flag <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                    end
                end

                // First byte bit goes out straight from tx_data so MISO leads by no extra cycle
                if (w_tx_load) begin
                    r_tx_latched <= 1'b1;
                    r_tx_active  <= 1'b1;
                    r_miso       <= tx_data[DATA_W-1];
                    r_tx_sr      <= {tx_data[DATA_W-2:0], 1'b0};
                    r_tx_cnt     <= CNT_W'(DATA_W - 1);
                end else if (r_tx_active) begin
                    if (r_tx_cnt == '0) begin
                        r_tx_active    <= 1'b0;
                        r_miso         <= 1'b0;
                        r_rd_addr_flag <= 1'b0;
                    end else begin
                        r_miso   <= r_tx_sr[DATA_W-1];
                        r_tx_sr  <= {r_tx_sr[DATA_W-2:0], 1'b0};
                        r_tx_cnt <= r_tx_cnt - CNT_W'(1);
                    end
                end
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign MISO     = r_miso;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed self-checking bench for spi_slave_fsm: inputs driven and outputs checked on the
// falling clock edge, expected values hand-computed from the frame encodings.
module tb_spi_slave_fsm;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       MISO;

    int n_pass  = 0;
    int n_total = 0;
    int rv_cnt  = 0;
    int miso_hi = 0;

    spi_slave_fsm #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .MISO     (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for rx_valid strobes and MISO high cycles
    always @(negedge clk) begin
        if (rx_valid === 1'b1) rv_cnt  = rv_cnt + 1;
        if (MISO === 1'b1)     miso_hi = miso_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Select, then present frame bits 9..0; returns on the negedge where rx_valid should be high
    task automatic send_frame(input logic [9:0] f);
        SS_n = 1'b0;
        @(negedge clk);
        for (int i = 9; i >= 0; i--) begin
            MOSI = f[i];
            @(negedge clk);
        end
        MOSI = 1'b0;
    endtask

    task automatic deselect();
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] byte_a5;
        logic [7:0] byte_5a;
        byte_a5  = 8'hA5;
        byte_5a  = 8'h5A;
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_rx_data",  32'(rx_data),  32'h0);
        check("reset_miso",     32'(MISO),     32'h0);
        check("reset_flag",     32'(dut.r_rd_addr_flag), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write address frame
        rv_cnt = 0; miso_hi = 0;
        send_frame(10'h005);
        check("wa_rx_valid", 32'(rx_valid), 32'h1);
        check("wa_rx_data",  32'(rx_data),  32'h005);
        @(negedge clk);
        check("wa_rx_valid_drop", 32'(rx_valid), 32'h0);
        repeat (3) @(negedge clk);
        check("wa_single_pulse", 32'(rv_cnt),  32'd1);
        check("wa_miso_quiet",   32'(miso_hi), 32'd0);
        deselect();

        // Write data frame
        send_frame(10'h1A5);
        check("wd_rx_valid", 32'(rx_valid), 32'h1);
        check("wd_rx_data",  32'(rx_data),  32'h1A5);
        check("wd_flag",     32'(dut.r_rd_addr_flag), 32'h0);
        deselect();
        check("wd_rx_data_hold", 32'(rx_data), 32'h1A5);

        // Read address frame sets the flag
        send_frame(10'h205);
        check("ra_rx_valid", 32'(rx_valid), 32'h1);
        check("ra_rx_data",  32'(rx_data),  32'h205);
        check("ra_flag",     32'(dut.r_rd_addr_flag), 32'h1);
        deselect();

        // Read data frame; tx_valid already high must not be taken before the cycle after rx_valid
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        send_frame(10'h3F0);
        check("rd_rx_valid", 32'(rx_valid), 32'h1);
        check("rd_rx_data",  32'(rx_data),  32'h3F0);
        check("rd_miso_pre", 32'(MISO),     32'h0);
        @(negedge clk);
        check("rd_miso_wait", 32'(MISO), 32'h0);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            check($sformatf("rd_miso_bit%0d", i), 32'(MISO), 32'(byte_a5[i]));
        end
        @(negedge clk);
        check("rd_miso_after", 32'(MISO), 32'h0);
        check("rd_flag_clear", 32'(dut.r_rd_addr_flag), 32'h0);
        miso_hi = 0;
        repeat (4) @(negedge clk);
        check("rd_no_relatch", 32'(miso_hi), 32'd0);
        deselect();

        // Read-data-looking frame with flag clear decodes as read address
        miso_hi = 0;
        send_frame(10'h3F0);
        check("rf_rx_data", 32'(rx_data), 32'h3F0);
        check("rf_flag",    32'(dut.r_rd_addr_flag), 32'h1);
        repeat (10) @(negedge clk);
        check("rf_miso_quiet", 32'(miso_hi), 32'd0);
        deselect();

        // Abort after 6 bits, then a clean frame
        rv_cnt = 0;
        SS_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            MOSI = ~MOSI;
            @(negedge clk);
        end
        deselect();
        repeat (3) @(negedge clk);
        check("ab_no_valid", 32'(rv_cnt), 32'd0);
        check("ab_rx_data",  32'(rx_data), 32'h3F0);
        check("ab_flag",     32'(dut.r_rd_addr_flag), 32'h1);
        send_frame(10'h0F0);
        check("ab_next_valid", 32'(rx_valid), 32'h1);
        check("ab_next_data",  32'(rx_data),  32'h0F0);
        deselect();

        // Async reset while MISO presents bit 3
        tx_data = 8'h5A;
        send_frame(10'h3C3);
        check("rs_rx_data", 32'(rx_data), 32'h3C3);
        @(negedge clk);
        for (int i = 7; i >= 3; i--) begin
            @(negedge clk);
            check($sformatf("rs_miso_bit%0d", i), 32'(MISO), 32'(byte_5a[i]));
        end
        rst_n = 1'b0;
        #1;
        check("rs_miso",     32'(MISO),     32'h0);
        check("rs_rx_valid", 32'(rx_valid), 32'h0);
        check("rs_rx_data",  32'(rx_data),  32'h0);
        check("rs_flag",     32'(dut.r_rd_addr_flag), 32'h0);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(10'h1A5);
        check("rs_next_valid", 32'(rx_valid), 32'h1);
        check("rs_next_data",  32'(rx_data),  32'h1A5);
        deselect();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
